cordic_rom_mc: RTL and testbench

- Parametrised, multi-channel successor to the single-channel loadable-LUT sine generator.
- A write phase loads a quarter-wave table of {base, slope} entries into internal RAM.
- A run phase time-multiplexes CH phase accumulators through one shared lookup/interpolation pipeline.
- Output is one signed sample per clock, tagged with its channel. Per-channel phase clear and quadrant folding are new.

---
 rtl/cordic_rom_mc_pkg.sv | 25 ++
 rtl/cordic_lut_ram.sv | 26 ++
 rtl/cordic_rom_mc.sv | 126 ++++++++++++
 tb/tb_cordic_rom_mc.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_rom_mc_pkg.sv
// Shared constants and helpers for the multi-channel LUT sine generator.
// LUT word layout: [BASE_MSB:BASE_LSB] unsigned base, [SLOPE_MSB:0] unsigned slope.
// round_sat: rounds a MAG_W-bit magnitude to out_w-bit signed range (half up),
//            saturating to the largest positive out_w-bit value.
package cordic_rom_mc_pkg;

    localparam int BASE_MSB  = 47;
    localparam int BASE_LSB  = 24;
    localparam int SLOPE_MSB = 23;
    localparam int MAG_W     = 24;

    function automatic logic [MAG_W-1:0] round_sat(input logic [MAG_W-1:0] mag, input int out_w);
        logic [MAG_W:0] sum;
        logic [MAG_W:0] lim;
        // Add half an output LSB, then drop the fraction; one extra bit of
        // headroom stops the rounding carry from wrapping.
        sum = {1'b0, mag} + ((MAG_W+1)'(1) << (MAG_W - out_w));
        sum = sum >> (MAG_W + 1 - out_w);
        lim = ((MAG_W+1)'(1) << (out_w - 1)) - (MAG_W+1)'(1);
        if (sum > lim)
            sum = lim;
        return sum[MAG_W-1:0];
    endfunction

endpackage

// File: rtl/cordic_lut_ram.sv
// Quarter-wave LUT storage: one write port, one registered read port.
// Ports: clk; we/waddr/wdata write port; re/raddr read request; rdata
// registered read data (holds when re is low). Contents are not reset.
module cordic_lut_ram #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 48
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
        if (re)
            rdata <= mem[raddr];
    end

endmodule

// File: rtl/cordic_rom_mc.sv
// Multi-channel loadable-LUT sine generator.
// CH phase accumulators share one fold / lookup / interpolate / round pipeline,
// one channel slot per clock. Output sample is valid 4 clocks after its slot.
// Ports: clk, reset (sync, active low), cen (active-low enable, high freezes),
// wen (active-low LUT write), waddr/wdata (LUT load), fcw/offset (packed per
// channel), phase_clr (per channel, sampled at its slot), sin_amp/out_ch/out_valid.
module cordic_rom_mc
    import cordic_rom_mc_pkg::*;
#(
    parameter int CH      = 4,
    parameter int PHASE_W = 16,
    parameter int ADDR_W  = 6,
    parameter int DATA_W  = 48,
    parameter int OUT_W   = 16,
    localparam int CH_W   = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cen,
    input  logic                    wen,
    input  logic [ADDR_W-1:0]       waddr,
    input  logic [DATA_W-1:0]       wdata,
    input  logic [CH*PHASE_W-1:0]   fcw,
    input  logic [CH*PHASE_W-1:0]   offset,
    input  logic [CH-1:0]           phase_clr,
    output logic [OUT_W-1:0]        sin_amp,
    output logic [CH_W-1:0]         out_ch,
    output logic                    out_valid
);

    localparam int FRAC_W = PHASE_W - 2 - ADDR_W;
    localparam int PROD_W = MAG_W + FRAC_W;
    localparam int STAGES = 4;

    logic run_en, wr_en;
    assign run_en = reset & ~cen &  wen;
    assign wr_en  = reset & ~cen & ~wen;

    logic [PHASE_W-1:0] acc [CH];
    logic [CH_W-1:0]    slot;
    logic [STAGES:0]    vld_pipe;   // [0]=S1 .. [3]=S4 inputs, [STAGES]=out_valid

    // Slot selection and quadrant fold
    logic [PHASE_W-1:0] cur_fcw, cur_phase;
    logic [1:0]         cur_q;
    logic [PHASE_W-3:0] cur_r;

    always_comb begin
        cur_fcw   = fcw[slot*PHASE_W +: PHASE_W];
        cur_phase = acc[slot] + offset[slot*PHASE_W +: PHASE_W];
        cur_q     = cur_phase[PHASE_W-1:PHASE_W-2];
        // Odd quadrants run the table backwards.
        cur_r     = cur_q[0] ? ~cur_phase[PHASE_W-3:0] : cur_phase[PHASE_W-3:0];
    end

    // Stage registers
    logic [1:0]         s1_q, s2_q, s3_q, s4_q;
    logic [ADDR_W-1:0]  s1_idx;
    logic [FRAC_W-1:0]  s1_frac, s2_frac;
    logic [CH_W-1:0]    s1_ch, s2_ch, s3_ch, s4_ch;
    logic [DATA_W-1:0]  lut_word;
    logic [MAG_W-1:0]   s3_base, s3_prod, s4_mag;

    cordic_lut_ram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_lut (
        .clk   (clk),
        .we    (wr_en),
        .waddr (waddr),
        .wdata (wdata),
        .re    (run_en),
        .raddr (s1_idx),
        .rdata (lut_word)
    );

    logic [MAG_W:0]   mag_sum;
    logic [OUT_W-1:0] m;

    assign mag_sum = {1'b0, s3_base} + {1'b0, s3_prod};
    assign m       = OUT_W'(round_sat(s4_mag, OUT_W));

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < CH; i++)
                acc[i] <= '0;
            slot      <= '0;
            vld_pipe  <= '0;
            sin_amp   <= '0;
            out_ch    <= '0;
        end else if (cen) begin
            vld_pipe[STAGES] <= 1'b0;
        end else if (!wen) begin
            vld_pipe <= '0;
        end else begin
            // Slot phase uses the pre-clear accumulator value.
            acc[slot] <= phase_clr[slot] ? '0 : acc[slot] + cur_fcw;
            slot      <= (slot == CH_W'(CH - 1)) ? '0 : slot + 1'b1;
            vld_pipe  <= {vld_pipe[STAGES-1:0], 1'b1};

            s1_q    <= cur_q;
            s1_idx  <= cur_r[PHASE_W-3 -: ADDR_W];
            s1_frac <= cur_r[FRAC_W-1:0];
            s1_ch   <= slot;

            s2_q    <= s1_q;
            s2_frac <= s1_frac;
            s2_ch   <= s1_ch;

            s3_q    <= s2_q;
            s3_ch   <= s2_ch;
            s3_base <= lut_word[BASE_MSB:BASE_LSB];
            s3_prod <= MAG_W'((PROD_W'(lut_word[SLOPE_MSB:0]) * PROD_W'(s2_frac)) >> FRAC_W);

            s4_q    <= s3_q;
            s4_ch   <= s3_ch;
            s4_mag  <= mag_sum[MAG_W] ? '1 : mag_sum[MAG_W-1:0];

            // Sample/channel only move on a real sample so they hold otherwise.
            if (vld_pipe[STAGES-1]) begin
                sin_amp <= s4_q[1] ? -m : m;
                out_ch  <= s4_ch;
            end
        end
    end

    assign out_valid = vld_pipe[STAGES];

endmodule

// File: tb/tb_cordic_rom_mc.sv
module tb_cordic_rom_mc;

    localparam int CH = 4, PW = 16, AW = 6, DW = 48, OW = 16;

    logic                 clk = 1'b0;
    logic                 reset, cen, wen;
    logic [AW-1:0]        waddr;
    logic [DW-1:0]        wdata;
    logic [CH*PW-1:0]     fcw, offset;
    logic [CH-1:0]        phase_clr;
    logic signed [OW-1:0] sin_amp;
    logic [1:0]           out_ch;
    logic                 out_valid;

    int checks = 0;
    int errors = 0;

    cordic_rom_mc #(.CH(CH), .PHASE_W(PW), .ADDR_W(AW), .DATA_W(DW), .OUT_W(OW)) dut (
        .clk(clk), .reset(reset), .cen(cen), .wen(wen), .waddr(waddr), .wdata(wdata),
        .fcw(fcw), .offset(offset), .phase_clr(phase_clr),
        .sin_amp(sin_amp), .out_ch(out_ch), .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    // Capture every valid output sample in arrival order.
    logic signed [OW-1:0] ampq[$];
    logic [1:0]           chq[$];
    always @(negedge clk)
        if (out_valid === 1'b1) begin
            ampq.push_back(sin_amp);
            chq.push_back(out_ch);
        end

    // Expected sample for a phase when lut[k] = {k<<18, 0}.
    function automatic logic signed [15:0] exp_lin(input logic [15:0] p);
        logic [13:0] r;
        int mm;
        r  = p[14] ? ~p[13:0] : p[13:0];
        mm = int'(r[13:8]) * 512;
        return p[15] ? 16'(-mm) : 16'(mm);
    endfunction

    task automatic clr_cap();
        ampq.delete();
        chq.delete();
    endtask

    task automatic run(input int n);
        cen = 1'b0; wen = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic stop();
        cen = 1'b1;
        @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        reset = 1'b0; cen = 1'b1; wen = 1'b1;
        repeat (n) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic write_lut(input int a, input logic [DW-1:0] d);
        cen = 1'b0; wen = 1'b0; waddr = AW'(a); wdata = d;
        @(negedge clk);
    endtask

    task automatic load_linear();
        for (int k = 0; k < 64; k++)
            write_lut(k, {24'(k << 18), 24'h000000});
        cen = 1'b1; wen = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b0; cen = 1'b1; wen = 1'b1; waddr = '0; wdata = '0;
        fcw = '0; offset = '0; phase_clr = '0;
        repeat (2) @(negedge clk);
        checks++;
        if (sin_amp !== 16'sd0) begin errors++; $display("FAIL reset_sin_amp: got %0d expected 0", sin_amp); end
        checks++;
        if (out_ch !== 2'd0) begin errors++; $display("FAIL reset_out_ch: got %0d expected 0", out_ch); end
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b expected 0", out_valid); end
        reset = 1'b1;
        @(negedge clk);
    endtask

    // Runs one full period on every channel (fcw 0x0100 each) and checks
    // first-output latency plus the rising first quadrant.
    task automatic test_linear();
        fcw = {4{16'h0100}}; offset = '0;
        clr_cap();
        cen = 1'b0; wen = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0) begin errors++; $display("FAIL latency_early_%0d: got %0b expected 0", i, out_valid); end
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_ch !== 2'd0) begin
            errors++; $display("FAIL latency_first: got valid=%0b ch=%0d expected valid=1 ch=0", out_valid, out_ch);
        end
        run(1024);
        stop();
        checks++;
        if (ampq.size() < 1025) begin
            errors++; $display("FAIL linear_count: got %0d expected >=1025", ampq.size());
        end else begin
            for (int n = 0; n < 64; n++) begin
                checks++;
                if (ampq[4*n] !== 16'(n * 512)) begin
                    errors++; $display("FAIL linear_q0_%0d: got %0d expected %0d", n, ampq[4*n], n * 512);
                end
            end
        end
    endtask

    // Remaining quadrants of the same capture, plus period and channel order.
    task automatic test_full_cycle();
        logic signed [15:0] e;
        if (ampq.size() < 1025) begin
            checks++; errors++; $display("FAIL full_cycle_count: got %0d expected >=1025", ampq.size());
        end else begin
            for (int n = 64; n < 256; n++) begin
                if (n < 128)      e = 16'((127 - n) * 512);
                else if (n < 192) e = 16'(-((n - 128) * 512));
                else              e = 16'(-((255 - n) * 512));
                checks++;
                if (ampq[4*n] !== e) begin
                    errors++; $display("FAIL full_cycle_%0d: got %0d expected %0d", n, ampq[4*n], e);
                end
            end
            checks++;
            if (ampq[1024] !== 16'sd0) begin errors++; $display("FAIL period_256: got %0d expected 0", ampq[1024]); end
            for (int i = 0; i < 1025; i++) begin
                checks++;
                if (chq[i] !== 2'(i % 4) || ampq[i] !== ampq[i - (i % 4)]) begin
                    errors++; $display("FAIL equal_channels_%0d: got ch=%0d amp=%0d expected ch=%0d amp=%0d",
                                       i, chq[i], ampq[i], i % 4, ampq[i - (i % 4)]);
                end
            end
        end
    endtask

    task automatic test_interp();
        logic signed [15:0] iexp [4];
        iexp = '{16'sd0, 16'sd1, 16'sd512, 16'sd512};
        do_reset(2);
        write_lut(0, {24'h000000, 24'h000200});
        cen = 1'b1; wen = 1'b1;
        fcw = {4{16'h0080}}; offset = '0;
        @(negedge clk);
        clr_cap();
        run(17);
        stop();
        checks++;
        if (ampq.size() < 13) begin
            errors++; $display("FAIL interp_count: got %0d expected >=13", ampq.size());
        end else begin
            for (int n = 0; n < 4; n++) begin
                checks++;
                if (ampq[4*n] !== iexp[n]) begin
                    errors++; $display("FAIL interp_%0d: got %0d expected %0d", n, ampq[4*n], iexp[n]);
                end
            end
        end
        write_lut(0, 48'h0);
        cen = 1'b1; wen = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_multichannel();
        int f [4];
        f = '{32'h0100, 32'h0200, 32'h0300, 32'h0400};
        do_reset(2);
        fcw = {16'h0400, 16'h0300, 16'h0200, 16'h0100}; offset = '0;
        clr_cap();
        cen = 1'b0; wen = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0) begin errors++; $display("FAIL mc_latency_early_%0d: got %0b expected 0", i, out_valid); end
        end
        run(320);
        stop();
        checks++;
        if (ampq.size() != 320) begin
            errors++; $display("FAIL mc_count: got %0d expected 320", ampq.size());
        end else begin
            for (int i = 0; i < 320; i++) begin
                checks++;
                if (chq[i] !== 2'(i % 4) || ampq[i] !== exp_lin(16'((i / 4) * f[i % 4]))) begin
                    errors++; $display("FAIL mc_%0d: got ch=%0d amp=%0d expected ch=%0d amp=%0d",
                                       i, chq[i], ampq[i], i % 4, exp_lin(16'((i / 4) * f[i % 4])));
                end
            end
        end
    endtask

    task automatic test_offset();
        do_reset(2);
        fcw = {4{16'h0100}}; offset = {16'h0000, 16'h0000, 16'h8000, 16'h0000};
        clr_cap();
        run(260);
        stop();
        checks++;
        if (ampq.size() < 256) begin
            errors++; $display("FAIL offset_count: got %0d expected >=256", ampq.size());
        end else begin
            for (int n = 0; n < 64; n++) begin
                checks++;
                if (ampq[4*n+1] !== 16'(-(n * 512)) || ampq[4*n] !== 16'(n * 512)) begin
                    errors++; $display("FAIL offset_%0d: got ch0=%0d ch1=%0d expected ch0=%0d ch1=%0d",
                                       n, ampq[4*n], ampq[4*n+1], n * 512, -(n * 512));
                end
            end
        end
        offset = '0;
    endtask

    task automatic test_phase_clr();
        logic signed [15:0] e;
        do_reset(2);
        fcw = {4{16'h0100}}; offset = '0;
        clr_cap();
        run(40);
        phase_clr = 4'b0100;
        run(4);
        phase_clr = '0;
        run(44);
        stop();
        checks++;
        if (ampq.size() != 84) begin
            errors++; $display("FAIL clr_count: got %0d expected 84", ampq.size());
        end else begin
            for (int n = 0; n < 21; n++) begin
                e = (n <= 10) ? exp_lin(16'(n * 256)) : exp_lin(16'((n - 11) * 256));
                checks++;
                if (ampq[4*n+2] !== e) begin
                    errors++; $display("FAIL clr_ch2_%0d: got %0d expected %0d", n, ampq[4*n+2], e);
                end
                checks++;
                if (ampq[4*n] !== exp_lin(16'(n * 256))) begin
                    errors++; $display("FAIL clr_ch0_%0d: got %0d expected %0d", n, ampq[4*n], exp_lin(16'(n * 256)));
                end
            end
        end
    endtask

    task automatic test_cen_pause();
        int f [4];
        f = '{32'h0100, 32'h0200, 32'h0300, 32'h0400};
        do_reset(2);
        fcw = {16'h0400, 16'h0300, 16'h0200, 16'h0100}; offset = '0;
        clr_cap();
        run(10);
        cen = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0) begin errors++; $display("FAIL pause_valid_%0d: got %0b expected 0", i, out_valid); end
            checks++;
            if (sin_amp !== 16'sd1024 || out_ch !== 2'd1) begin
                errors++; $display("FAIL pause_hold_%0d: got amp=%0d ch=%0d expected amp=1024 ch=1", i, sin_amp, out_ch);
            end
        end
        run(120);
        stop();
        checks++;
        if (ampq.size() != 126) begin
            errors++; $display("FAIL pause_count: got %0d expected 126", ampq.size());
        end else begin
            for (int i = 0; i < 126; i++) begin
                checks++;
                if (chq[i] !== 2'(i % 4) || ampq[i] !== exp_lin(16'((i / 4) * f[i % 4]))) begin
                    errors++; $display("FAIL pause_seq_%0d: got ch=%0d amp=%0d expected ch=%0d amp=%0d",
                                       i, chq[i], ampq[i], i % 4, exp_lin(16'((i / 4) * f[i % 4])));
                end
            end
        end
    endtask

    task automatic test_reset_midrun();
        run(7);
        reset = 1'b0;   // cen/wen still in run mode: reset must win
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (sin_amp !== 16'sd0 || out_ch !== 2'd0 || out_valid !== 1'b0) begin
                errors++; $display("FAIL midrun_reset_%0d: got amp=%0d ch=%0d valid=%0b expected 0/0/0",
                                   i, sin_amp, out_ch, out_valid);
            end
        end
        reset = 1'b1; cen = 1'b1;
        fcw = {4{16'h0100}}; offset = '0;
        @(negedge clk);
        clr_cap();
        run(260);
        stop();
        checks++;
        if (ampq.size() != 256) begin
            errors++; $display("FAIL rerun_count: got %0d expected 256", ampq.size());
        end else begin
            for (int n = 0; n < 64; n++) begin
                checks++;
                if (ampq[4*n] !== 16'(n * 512) || ampq[4*n+3] !== 16'(n * 512)) begin
                    errors++; $display("FAIL rerun_%0d: got ch0=%0d ch3=%0d expected %0d", n, ampq[4*n], ampq[4*n+3], n * 512);
                end
            end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        load_linear();
        test_linear();
        test_full_cycle();
        test_interp();
        test_multichannel();
        test_offset();
        test_phase_clr();
        test_cen_pause();
        test_reset_midrun();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
